anemometre_sample_logger: RTL and testbench

Avalon-MM write master that streams 32-bit anemometer measurement words into the on-chip RAM slave as a circular log buffer. It sits between the anemometer measurement core (sample producer) and the system interconnect. Samples are buffered in a 4-entry FIFO so that interconnect `waitrequest` stalls are absorbed. The Nios software reads the log back through the RAM's other port using `wr_ptr` and `wrapped`.

---
 rtl/anemometre_pkg.sv | 25 ++
 rtl/anemometre_sample_logger_fifo.sv | 82 ++++++++
 rtl/anemometre_sample_logger.sv | 189 ++++++++++++++++++
 tb/tb_anemometre_sample_logger.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/anemometre_pkg.sv
// Shared types and constants for the anemometer sample logger.
package anemometre_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam int          FIFO_DEPTH = 4;
  localparam int          FIFO_AW    = $clog2(FIFO_DEPTH);
  localparam logic [15:0] OVF_MAX    = 16'hFFFF;

  // Saturating increment for the dropped-sample counter.
  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    logic [15:0] result;
    if (value == OVF_MAX) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/anemometre_sample_logger_fifo.sv
// Small synchronous FIFO that absorbs interconnect stalls between the
// sample producer and the Avalon write master. Head word is read combinationally.
module logger_fifo
  import anemometre_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] rd_q, rd_d;
  logic [FIFO_AW-1:0] wr_q, wr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               push_ok_s;
  logic               pop_ok_s;

  assign full_o    = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign push_ok_s = push_i & ~full_o;
  assign pop_ok_s  = pop_i & ~empty_o;
  assign head_o    = mem_q[rd_q];

  // Pointer and occupancy next-state; flush wins over any push/pop.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok_s) begin
        wr_d = wr_q + FIFO_AW'(1);
      end else begin
        wr_d = wr_q;
      end
      if (pop_ok_s) begin
        rd_d = rd_q + FIFO_AW'(1);
      end else begin
        rd_d = rd_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/anemometre_sample_logger.sv
// Avalon-MM write master logging anemometer samples into a circular RAM buffer,
// with a small FIFO to ride through waitrequest stalls.
module anemometre_sample_logger
  import anemometre_pkg::*;
#(
  parameter int ADDR_W    = 15,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 5120,
  parameter int PTR_W     = 13
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              clear,
  input  logic              sample_valid,
  input  logic [31:0]       sample_data,
  output logic              sample_ready,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  output logic [PTR_W-1:0]  wr_ptr,
  output logic              wrapped,
  output logic [15:0]       overflow_cnt
);

  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);

  state_e             state_q, state_d;
  logic               avm_write_q, avm_write_d;
  logic [ADDR_W-1:0]  avm_address_q, avm_address_d;
  logic [31:0]        avm_writedata_q, avm_writedata_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic               wrapped_q, wrapped_d;
  logic [15:0]        ovf_q, ovf_d;

  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [31:0]        fifo_head_s;
  logic               flushing_s;
  logic               push_s;
  logic               pop_s;
  logic               drop_s;
  logic               complete_s;
  logic               clr_now_s;
  logic [ADDR_W-1:0]  ptr_ext_s;

  assign flushing_s   = (state_q == FLUSH);
  assign sample_ready = enable & ~fifo_full_s & ~clear & ~flushing_s;
  assign push_s       = sample_valid & sample_ready;
  assign drop_s       = sample_valid & enable & ~sample_ready;

  logger_fifo #(
    .DATA_W (32)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush_i (clear),
    .push_i  (push_s),
    .data_i  (sample_data),
    .pop_i   (pop_s),
    .head_o  (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Write-master FSM, pointer/wrap bookkeeping and overflow counting.
  always_comb begin
    state_d         = state_q;
    avm_write_d     = avm_write_q;
    avm_address_d   = avm_address_q;
    avm_writedata_d = avm_writedata_q;
    pop_s           = 1'b0;
    complete_s      = 1'b0;
    clr_now_s       = 1'b0;

    case (state_q)
      IDLE: begin
        if (clear) begin
          clr_now_s = 1'b1;
        end else if (enable && !fifo_empty_s) begin
          pop_s   = 1'b1;
          state_d = WRITE;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (!avm_waitrequest) begin
          complete_s = 1'b1;
          if (clear) begin
            // Write landed this cycle; clear applies now, increment discarded.
            clr_now_s   = 1'b1;
            avm_write_d = 1'b0;
            state_d     = IDLE;
          end else if (enable && !fifo_empty_s) begin
            pop_s = 1'b1;
          end else begin
            avm_write_d = 1'b0;
            state_d     = IDLE;
          end
        end else if (clear) begin
          state_d = FLUSH;
        end else begin
          state_d = WRITE;
        end
      end
      FLUSH: begin
        if (!avm_waitrequest) begin
          clr_now_s   = 1'b1;
          avm_write_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = FLUSH;
        end
      end
      default: begin
        avm_write_d = 1'b0;
        state_d     = IDLE;
      end
    endcase

    wr_ptr_d  = wr_ptr_q;
    wrapped_d = wrapped_q;
    if (clr_now_s) begin
      wr_ptr_d  = '0;
      wrapped_d = 1'b0;
    end else if (complete_s) begin
      if (wr_ptr_q == LAST_PTR) begin
        wr_ptr_d  = '0;
        wrapped_d = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    // Address uses the post-completion pointer so back-to-back pops advance.
    ptr_ext_s = ADDR_W'(wr_ptr_d);
    if (pop_s) begin
      avm_write_d     = 1'b1;
      avm_writedata_d = fifo_head_s;
      avm_address_d   = BASE_A + (ptr_ext_s << 2);
    end else begin
      avm_writedata_d = avm_writedata_q;
    end

    if (clr_now_s) begin
      ovf_d = '0;
    end else if (drop_s) begin
      ovf_d = sat_inc(ovf_q);
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      avm_write_q     <= 1'b0;
      avm_address_q   <= '0;
      avm_writedata_q <= '0;
      wr_ptr_q        <= '0;
      wrapped_q       <= 1'b0;
      ovf_q           <= '0;
    end else begin
      state_q         <= state_d;
      avm_write_q     <= avm_write_d;
      avm_address_q   <= avm_address_d;
      avm_writedata_q <= avm_writedata_d;
      wr_ptr_q        <= wr_ptr_d;
      wrapped_q       <= wrapped_d;
      ovf_q           <= ovf_d;
    end
  end

  assign avm_write      = avm_write_q;
  assign avm_address    = avm_address_q;
  assign avm_writedata  = avm_writedata_q;
  assign avm_byteenable = 4'b1111;
  assign wr_ptr         = wr_ptr_q;
  assign wrapped        = wrapped_q;
  assign overflow_cnt   = ovf_q;

endmodule

// File: tb/tb_anemometre_sample_logger.sv
// Directed, table-driven bench for anemometre_sample_logger (DEPTH=4 so wrap is reachable).
module tb_anemometre_sample_logger;

  localparam int ADDR_W = 15;
  localparam int PTR_W  = 13;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enable;
  logic              clear;
  logic              sample_valid;
  logic [31:0]       sample_data;
  logic              sample_ready;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [3:0]        avm_byteenable;
  logic              avm_waitrequest;
  logic [PTR_W-1:0]  wr_ptr;
  logic              wrapped;
  logic [15:0]       overflow_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  anemometre_sample_logger #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (0),
    .DEPTH     (DEPTH),
    .PTR_W     (PTR_W)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .clear           (clear),
    .sample_valid    (sample_valid),
    .sample_data     (sample_data),
    .sample_ready    (sample_ready),
    .avm_address     (avm_address),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_waitrequest (avm_waitrequest),
    .wr_ptr          (wr_ptr),
    .wrapped         (wrapped),
    .overflow_cnt    (overflow_cnt)
  );

  typedef struct {
    logic        en;
    logic        clr;
    logic        vld;
    logic [31:0] d;
    logic        wt;
    logic        er;
    logic        ew;
    logic [14:0] ea;
    logic [31:0] ed;
    logic [12:0] ep;
    logic        ewr;
    logic [15:0] eo;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic en, input logic clr, input logic vld,
                              input logic [31:0] d, input logic wt,
                              input logic er, input logic ew, input logic [14:0] ea,
                              input logic [31:0] ed, input logic [12:0] ep,
                              input logic ewr, input logic [15:0] eo);
    vec_t v;
    v.en = en; v.clr = clr; v.vld = vld; v.d = d; v.wt = wt;
    v.er = er; v.ew = ew; v.ea = ea; v.ed = ed; v.ep = ep; v.ewr = ewr; v.eo = eo;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic clr, input logic vld,
                       input logic [31:0] d, input logic wt);
    enable          = en;
    clear           = clr;
    sample_valid    = vld;
    sample_data     = d;
    avm_waitrequest = wt;
  endtask

  task automatic chk_regs(input int idx, input logic ew, input logic [14:0] ea,
                          input logic [31:0] ed, input logic [12:0] ep,
                          input logic ewr, input logic [15:0] eo);
    chk("avm_write", idx, 32'(avm_write), 32'(ew));
    chk("avm_address", idx, 32'(avm_address), 32'(ea));
    chk("avm_writedata", idx, avm_writedata, ed);
    chk("wr_ptr", idx, 32'(wr_ptr), 32'(ep));
    chk("wrapped", idx, 32'(wrapped), 32'(ewr));
    chk("overflow_cnt", idx, 32'(overflow_cnt), 32'(eo));
  endtask

  initial begin
    // en clr vld data wait | ready write addr data ptr wrapped ovf (after the edge)
    // back-to-back logging
    vq.push_back(mk(1'b1,1'b0,1'b1,32'hA0,1'b0, 1'b1,1'b0,15'h0,32'h0, 13'd0,1'b0,16'd0));
    vq.push_back(mk(1'b1,1'b0,1'b1,32'hA1,1'b0, 1'b1,1'b1,15'h0,32'hA0,13'd0,1'b0,16'd0));
    vq.push_back(mk(1'b1,1'b0,1'b1,32'hA2,1'b0, 1'b1,1'b1,15'h4,32'hA1,13'd1,1'b0,16'd0));
    vq.push_back(mk(1'b1,1'b0,1'b0,32'h0, 1'b0, 1'b1,1'b1,15'h8,32'hA2,13'd2,1'b0,16'd0));
    vq.push_back(mk(1'b1,1'b0,1'b0,32'h0, 1'b0, 1'b1,1'b0,15'h8,32'hA2,13'd3,1'b0,16'd0));
    // stall with 6 offered samples, then wrap
    vq.push_back(mk(1'b1,1'b0,1'b1,32'hB0,1'b0, 1'b1,1'b0,15'h8,32'hA2,13'd3,1'b0,16'd0));
    vq.push_back(mk(1'b1,1'b0,1'b1,32'hC0,1'b1, 1'b1,1'b1,15'hC,32'hB0,13'd3,1'b0,16'd0));
    vq.push_back(mk(1'b1,1'b0,1'b1,32'hC1,1'b1, 1'b1,1'b1,15'hC,32'hB0,13'd3,1'b0,16'd0));
    vq.push_back(mk(1'b1,1'b0,1'b1,32'hC2,1'b1, 1'b1,1'b1,15'hC,32'hB0,13'd3,1'b0,16'd0));
    vq.push_back(mk(1'b1,1'b0,1'b1,32'hC3,1'b1, 1'b1,1'b1,15'hC,32'hB0,13'd3,1'b0,16'd0));
    vq.push_back(mk(1'b1,1'b0,1'b1,32'hC4,1'b1, 1'b0,1'b1,15'hC,32'hB0,13'd3,1'b0,16'd1));
    vq.push_back(mk(1'b1,1'b0,1'b1,32'hC5,1'b1, 1'b0,1'b1,15'hC,32'hB0,13'd3,1'b0,16'd2));
    vq.push_back(mk(1'b1,1'b0,1'b1,32'hC6,1'b0, 1'b0,1'b1,15'h0,32'hC0,13'd0,1'b1,16'd3));
    vq.push_back(mk(1'b1,1'b0,1'b0,32'h0, 1'b0, 1'b1,1'b1,15'h4,32'hC1,13'd1,1'b1,16'd3));
    vq.push_back(mk(1'b1,1'b0,1'b0,32'h0, 1'b0, 1'b1,1'b1,15'h8,32'hC2,13'd2,1'b1,16'd3));
    vq.push_back(mk(1'b1,1'b0,1'b0,32'h0, 1'b0, 1'b1,1'b1,15'hC,32'hC3,13'd3,1'b1,16'd3));
    vq.push_back(mk(1'b1,1'b0,1'b0,32'h0, 1'b0, 1'b1,1'b0,15'hC,32'hC3,13'd0,1'b1,16'd3));
    // clear in IDLE, then samples ignored while disabled
    vq.push_back(mk(1'b1,1'b1,1'b1,32'hD0,1'b0, 1'b0,1'b0,15'hC,32'hC3,13'd0,1'b0,16'd0));
    vq.push_back(mk(1'b0,1'b0,1'b1,32'hE0,1'b0, 1'b0,1'b0,15'hC,32'hC3,13'd0,1'b0,16'd0));
    // clear during a stalled write goes through FLUSH
    vq.push_back(mk(1'b1,1'b0,1'b1,32'hF0,1'b1, 1'b1,1'b0,15'hC,32'hC3,13'd0,1'b0,16'd0));
    vq.push_back(mk(1'b1,1'b0,1'b1,32'hF1,1'b1, 1'b1,1'b1,15'h0,32'hF0,13'd0,1'b0,16'd0));
    vq.push_back(mk(1'b1,1'b0,1'b0,32'h0, 1'b1, 1'b1,1'b1,15'h0,32'hF0,13'd0,1'b0,16'd0));
    vq.push_back(mk(1'b1,1'b1,1'b1,32'hF2,1'b1, 1'b0,1'b1,15'h0,32'hF0,13'd0,1'b0,16'd1));
    vq.push_back(mk(1'b1,1'b0,1'b1,32'hF3,1'b1, 1'b0,1'b1,15'h0,32'hF0,13'd0,1'b0,16'd2));
    vq.push_back(mk(1'b1,1'b0,1'b0,32'h0, 1'b0, 1'b0,1'b0,15'h0,32'hF0,13'd0,1'b0,16'd0));
    vq.push_back(mk(1'b1,1'b0,1'b0,32'h0, 1'b0, 1'b1,1'b0,15'h0,32'hF0,13'd0,1'b0,16'd0));
    // enable falls mid-write; FIFO contents survive
    vq.push_back(mk(1'b1,1'b0,1'b1,32'h60,1'b1, 1'b1,1'b0,15'h0,32'hF0,13'd0,1'b0,16'd0));
    vq.push_back(mk(1'b1,1'b0,1'b1,32'h61,1'b1, 1'b1,1'b1,15'h0,32'h60,13'd0,1'b0,16'd0));
    vq.push_back(mk(1'b1,1'b0,1'b1,32'h62,1'b1, 1'b1,1'b1,15'h0,32'h60,13'd0,1'b0,16'd0));
    vq.push_back(mk(1'b0,1'b0,1'b0,32'h0, 1'b0, 1'b0,1'b0,15'h0,32'h60,13'd1,1'b0,16'd0));
    vq.push_back(mk(1'b0,1'b0,1'b1,32'h70,1'b0, 1'b0,1'b0,15'h0,32'h60,13'd1,1'b0,16'd0));
    vq.push_back(mk(1'b1,1'b0,1'b0,32'h0, 1'b0, 1'b1,1'b1,15'h4,32'h61,13'd1,1'b0,16'd0));
    vq.push_back(mk(1'b1,1'b0,1'b0,32'h0, 1'b0, 1'b1,1'b1,15'h8,32'h62,13'd2,1'b0,16'd0));
    vq.push_back(mk(1'b1,1'b0,1'b0,32'h0, 1'b0, 1'b1,1'b0,15'h8,32'h62,13'd3,1'b0,16'd0));

    // reset held for 3 cycles
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset sample_ready", -1, 32'(sample_ready), 32'd0);
    chk("reset byteenable", -1, 32'(avm_byteenable), 32'hF);
    chk_regs(-1, 1'b0, 15'h0, 32'h0, 13'd0, 1'b0, 16'd0);
    reset_n = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].en, vq[i].clr, vq[i].vld, vq[i].d, vq[i].wt);
      #1;
      chk("sample_ready", i, 32'(sample_ready), 32'(vq[i].er));
      @(posedge clk);
      #1;
      chk_regs(i, vq[i].ew, vq[i].ea, vq[i].ed, vq[i].ep, vq[i].ewr, vq[i].eo);
    end

    // saturation: clear, fill FIFO under a stalled write, then 65540 refusals
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    chk("sat clear ovf", 100, 32'(overflow_cnt), 32'd0);
    chk("sat clear ptr", 100, 32'(wr_ptr), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 32'h5A, 1'b1);
    repeat (5 + 65534) @(posedge clk);
    #1;
    chk("sat pre ovf", 101, 32'(overflow_cnt), 32'hFFFE);
    @(posedge clk);
    #1;
    chk("sat hit ovf", 102, 32'(overflow_cnt), 32'hFFFF);
    repeat (5) @(posedge clk);
    #1;
    chk("sat hold ovf", 103, 32'(overflow_cnt), 32'hFFFF);
    chk("sat write held", 103, 32'(avm_write), 32'd1);
    chk("sat addr held", 103, 32'(avm_address), 32'h0);
    chk("sat data held", 103, avm_writedata, 32'h5A);

    // reset during a stalled write drops avm_write on the next edge
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst mid-write avm_write", 104, 32'(avm_write), 32'd0);
    chk("rst mid-write ovf", 104, 32'(overflow_cnt), 32'd0);
    chk("rst mid-write ready", 104, 32'(sample_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
